// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants, types and cell addressing for the character RAM arbiter
package vram_pkg;
    localparam int COLS       = 80;
    localparam int ROWS       = 30;
    localparam int CELL_W     = 8;
    localparam int CELL_H     = 16;
    localparam int VRAM_DEPTH = 2400;
    localparam logic [7:0] CLEAR_CHAR = 8'h20;

    typedef logic [11:0] vram_addr_t;
    typedef logic [7:0]  char_t;

    typedef enum logic {CLR_IDLE, CLR_BUSY} clear_state_t;

    localparam vram_addr_t LAST_ADDR = vram_addr_t'(VRAM_DEPTH - 1);

    // row*80 + col built from shifts: r*64 + r*16 + c
    function automatic vram_addr_t cell_addr(input logic [4:0] r, input logic [6:0] c);
        return ({7'd0, r} << 6) + ({7'd0, r} << 4) + {5'd0, c};
    endfunction
endpackage

// File: rtl/vram_clear_engine.sv
// rtl/vram_clear_engine.sv - screen-clear FSM, walks every cell through free slots writing CLEAR_CHAR
module vram_clear_engine
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_req,
    input  logic       free_slot,
    output logic       clr_we,
    output vram_addr_t clr_addr,
    output logic       clear_busy
);
    clear_state_t state;
    vram_addr_t   cnt;
    logic         busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLR_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clear_req) begin
                        state  <= CLR_BUSY;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLR_BUSY: begin
                    if (free_slot) begin
                        if (cnt == LAST_ADDR) begin
                            state  <= CLR_IDLE;
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                end
                default: begin
                    state  <= CLR_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we     = busy_q;
    assign clr_addr   = cnt;
    assign clear_busy = busy_q;
endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display-fetch / writer arbiter for the text character RAM; VRAM_ARB_CLEAR_EN adds the clear engine
module vram_arbiter
    import vram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
`ifdef VRAM_ARB_CLEAR_EN
    input  logic        clear_req,
`endif
    output logic        clear_busy,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  char_code,
    output logic        char_valid
);
    logic [6:0] nc;
    logic       fetch_slot;
    logic       free_slot;
    vram_addr_t fetch_addr;
    logic       clr_we;
    vram_addr_t clr_addr;
    logic       fetch_d1;
    char_t      hold_q;
    logic       valid_q;

    // Fetch two pixels ahead so the code is ready when the next cell starts
    assign nc         = 7'((col + 10'd2) >> 3);
    assign fetch_slot = (row < 9'd480) && (col[2:0] == 3'd6) && (nc < 7'(COLS));
    assign fetch_addr = cell_addr(row[8:4], nc);
    assign free_slot  = !fetch_slot;

`ifdef VRAM_ARB_CLEAR_EN
    vram_clear_engine u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .free_slot  (free_slot),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr),
        .clear_busy (clear_busy)
    );
`else
    assign clr_we     = 1'b0;
    assign clr_addr   = '0;
    assign clear_busy = 1'b0;
`endif

    assign wr_ready = rst_n && free_slot && !clear_busy;

    always_comb begin
        ram_addr  = fetch_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rst_n && free_slot) begin
            if (clr_we) begin
                ram_addr  = clr_addr;
                ram_we    = 1'b1;
                ram_wdata = CLEAR_CHAR;
            end else if (wr_valid && wr_ready) begin
                ram_addr  = wr_addr;
                ram_wdata = wr_data;
                ram_we    = (wr_addr < vram_addr_t'(VRAM_DEPTH));
            end
        end
    end

    // Captured on the last pixel of a cell so the code is presented for the whole next cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_d1 <= 1'b0;
            hold_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            fetch_d1 <= fetch_slot;
            if (col[2:0] == 3'd7) begin
                hold_q  <= ram_rdata;
                valid_q <= fetch_d1;
            end
        end
    end

    assign char_code  = hold_q;
    assign char_valid = valid_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a 1-cycle RAM model and scoreboards
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
`ifdef VRAM_ARB_CLEAR_EN
    logic        clear_req;
`endif
    logic        clear_busy;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  char_code;
    logic        char_valid;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [0:4095];
    logic        do_fill;
    logic [7:0]  exp_q [$];
    logic [19:0] wq [$];

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef VRAM_ARB_CLEAR_EN
        .clear_req  (clear_req),
`endif
        .clear_busy (clear_busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .char_code  (char_code),
        .char_valid (char_valid)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) % 251);
    endfunction

    always @(posedge clk) begin
        if (do_fill) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic go(input logic [8:0] r, input logic [9:0] c, input logic wv,
                      input logic [11:0] wa, input logic [7:0] wd);
        @(posedge clk); #1;
        row = r; col = c; wr_valid = wv; wr_addr = wa; wr_data = wd;
`ifdef VRAM_ARB_CLEAR_EN
        clear_req = 1'b0;
`endif
        @(negedge clk);
    endtask

    task automatic fill_ram();
        @(posedge clk); #1 do_fill = 1'b1;
        @(posedge clk); #1 do_fill = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_n = 1'b0; row = 9'd100; col = 10'd300; wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 8'h11;
        fill_ram();
        @(negedge clk);
        tests++; if (char_code !== 8'h00) begin fails++; $display("FAIL reset_char_code got %h want 00", char_code); end
        tests++; if (char_valid !== 1'b0) begin fails++; $display("FAIL reset_char_valid got %b want 0", char_valid); end
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        tests++; if (clear_busy !== 1'b0) begin fails++; $display("FAIL reset_clear_busy got %b want 0", clear_busy); end
        @(posedge clk); #1;
        rst_n = 1'b1; row = 9'd0; col = 10'd1020; wr_valid = 1'b0;
        @(negedge clk);
        go(9'd0, 10'd1021, 1'b0, 12'd0, 8'h00);
        go(9'd0, 10'd1022, 1'b0, 12'd0, 8'h00);
        tests++; if (ram_addr !== 12'd0 || ram_we !== 1'b0) begin fails++; $display("FAIL prefetch_cell0 got addr %0d we %b want addr 0 we 0", ram_addr, ram_we); end
        exp_q.push_back(pat(0));
        go(9'd0, 10'd1023, 1'b0, 12'd0, 8'h00);
        go(9'd0, 10'd0, 1'b0, 12'd0, 8'h00);
        e = exp_q.pop_front();
        tests++; if (char_code !== e || char_valid !== 1'b1) begin fails++; $display("FAIL cell0_display got %h/%b want %h/1", char_code, char_valid, e); end
    endtask

    task automatic test_fetch_sweep();
        logic [7:0] e;
        for (int c = 0; c < 16; c++) begin
            go(9'd17, 10'(c), 1'b0, 12'd0, 8'h00);
            tests++; if (wr_ready !== ((c % 8) != 6)) begin fails++; $display("FAIL sweep_wr_ready col %0d got %b", c, wr_ready); end
            if (c == 6) begin
                tests++; if (ram_addr !== 12'd81 || ram_we !== 1'b0) begin fails++; $display("FAIL sweep_fetch got addr %0d we %b want 81 0", ram_addr, ram_we); end
                exp_q.push_back(pat(81));
            end
            if (c == 8) begin
                e = exp_q.pop_front();
                tests++; if (char_code !== e || char_valid !== 1'b1) begin fails++; $display("FAIL sweep_char got %h/%b want %h/1", char_code, char_valid, e); end
            end
            if (c == 15) begin
                tests++; if (char_code !== pat(81)) begin fails++; $display("FAIL sweep_char_hold got %h want %h", char_code, pat(81)); end
            end
        end
    endtask

    task automatic test_line_end();
        logic [7:0] e;
        for (int c = 630; c < 648; c++) begin
            go(9'd0, 10'(c), 1'b0, 12'd0, 8'h00);
            if (c == 630) begin
                tests++; if (ram_addr !== 12'd79 || wr_ready !== 1'b0) begin fails++; $display("FAIL last_fetch got addr %0d ready %b want 79 0", ram_addr, wr_ready); end
                exp_q.push_back(pat(79));
            end
            if (c == 632) begin
                e = exp_q.pop_front();
                tests++; if (char_code !== e || char_valid !== 1'b1) begin fails++; $display("FAIL last_cell got %h/%b want %h/1", char_code, char_valid, e); end
            end
            if (c == 638) begin
                tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL col638_nofetch got ready %b want 1", wr_ready); end
            end
            if (c == 640) begin
                tests++; if (char_valid !== 1'b0) begin fails++; $display("FAIL col640_valid got %b want 0", char_valid); end
            end
        end
    endtask

    task automatic test_writer_stall();
        int stall = 0;
        int c = 6;
        logic done = 1'b0;
        logic [19:0] w;
        logic [7:0] e;
        wq.push_back({12'd5, 8'h41});
        while (!done && stall < 8) begin
            go(9'd2, 10'(c), 1'b1, 12'd5, 8'h41);
            if (wr_ready) begin
                w = wq.pop_front();
                done = 1'b1;
                tests++; if (ram_we !== 1'b1 || ram_addr !== w[19:8] || ram_wdata !== w[7:0]) begin fails++; $display("FAIL write_xfer got we %b addr %0d data %h want 1 %0d %h", ram_we, ram_addr, ram_wdata, w[19:8], w[7:0]); end
            end else begin
                stall++;
            end
            c++;
        end
        tests++; if (!done || stall != 1) begin fails++; $display("FAIL write_stall got %0d cycles done %b want 1", stall, done); end
        go(9'd2, 10'(c), 1'b1, 12'd2400, 8'h77);
        tests++; if (wr_ready !== 1'b1 || ram_we !== 1'b0) begin fails++; $display("FAIL oob_drop got ready %b we %b want 1 0", wr_ready, ram_we); end
        go(9'd0, 10'd38, 1'b0, 12'd0, 8'h00);
        exp_q.push_back(8'h41);
        go(9'd0, 10'd39, 1'b0, 12'd0, 8'h00);
        go(9'd0, 10'd40, 1'b0, 12'd0, 8'h00);
        e = exp_q.pop_front();
        tests++; if (char_code !== e || char_valid !== 1'b1) begin fails++; $display("FAIL write_visible got %h/%b want %h/1", char_code, char_valid, e); end
    endtask

    task automatic test_blanking_throughput();
        int rdy = 0;
        int bad = 0;
        for (int c = 0; c < 16; c++) begin
            go(9'd480, 10'(c), 1'b1, 12'(100 + c), 8'(8'hA0 + c));
            if (wr_ready) rdy++;
            if (ram_we !== 1'b1 || ram_addr !== 12'(100 + c)) bad++;
        end
        go(9'd480, 10'd16, 1'b0, 12'd0, 8'h00);
        tests++; if (rdy != 16 || bad != 0) begin fails++; $display("FAIL blank_throughput got %0d ready %0d bad want 16 0", rdy, bad); end
    endtask

`ifdef VRAM_ARB_CLEAR_EN
    task automatic test_clear();
        logic [11:0] cq [$];
        int busy_cnt = 0;
        int rdy_bad = 0;
        int wr_bad = 0;
        int mem_bad = 0;
        int c = 1;
        logic [11:0] a;
        @(posedge clk); #1;
        row = 9'd480; col = 10'd0; wr_valid = 1'b0; clear_req = 1'b1;
        for (int i = 0; i < VRAM_DEPTH; i++) cq.push_back(12'(i));
        @(negedge clk);
        tests++; if (clear_busy !== 1'b0) begin fails++; $display("FAIL clear_busy_early got %b want 0", clear_busy); end
        while (c < 3000) begin
            go(9'd480, 10'(c % 1024), 1'b1, 12'd7, 8'h99);
            c++;
            if (!clear_busy) break;
            busy_cnt++;
            if (wr_ready !== 1'b0) rdy_bad++;
            if (ram_we === 1'b1 && cq.size() > 0) begin
                a = cq.pop_front();
                if (ram_addr !== a || ram_wdata !== CLEAR_CHAR) wr_bad++;
            end else begin
                wr_bad++;
            end
        end
        tests++; if (busy_cnt != VRAM_DEPTH || rdy_bad != 0) begin fails++; $display("FAIL clear_busy_len got %0d cycles %0d ready want 2400 0", busy_cnt, rdy_bad); end
        tests++; if (wr_bad != 0 || cq.size() != 0) begin fails++; $display("FAIL clear_writes got %0d bad %0d left want 0 0", wr_bad, cq.size()); end
        tests++; if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'd7 || ram_wdata !== 8'h99) begin fails++; $display("FAIL writer_after_clear got ready %b we %b addr %0d data %h", wr_ready, ram_we, ram_addr, ram_wdata); end
        go(9'd480, 10'(c % 1024), 1'b0, 12'd0, 8'h00);
        for (int i = 0; i < VRAM_DEPTH; i++)
            if (mem[i] !== ((i == 7) ? 8'h99 : CLEAR_CHAR)) mem_bad++;
        tests++; if (mem_bad != 0) begin fails++; $display("FAIL clear_contents got %0d wrong cells want 0", mem_bad); end
    endtask

    task automatic test_clear_reset();
        int writes = 0;
        int c = 1;
        int idle_bad = 0;
        int lo_bad = 0;
        int hi_bad = 0;
        fill_ram();
        @(posedge clk); #1;
        row = 9'd480; col = 10'd0; wr_valid = 1'b0; clear_req = 1'b1;
        @(negedge clk);
        while (writes < 1000 && c < 2000) begin
            go(9'd480, 10'(c), 1'b0, 12'd0, 8'h00);
            c++;
            if (ram_we === 1'b1) writes++;
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        tests++; if (clear_busy !== 1'b0 || ram_we !== 1'b0 || wr_ready !== 1'b0) begin fails++; $display("FAIL reset_abort got busy %b we %b ready %b want 0 0 0", clear_busy, ram_we, wr_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            go(9'd480, 10'(c + i), 1'b0, 12'd0, 8'h00);
            if (clear_busy !== 1'b0 || ram_we !== 1'b0) idle_bad++;
        end
        tests++; if (idle_bad != 0) begin fails++; $display("FAIL fsm_idle_after_reset got %0d busy cycles want 0", idle_bad); end
        for (int i = 0; i < 1000; i++) if (mem[i] !== CLEAR_CHAR) lo_bad++;
        for (int i = 1000; i < VRAM_DEPTH; i++) if (mem[i] !== pat(i)) hi_bad++;
        tests++; if (lo_bad != 0 || hi_bad != 0) begin fails++; $display("FAIL partial_clear got %0d low %0d high wrong want 0 0", lo_bad, hi_bad); end
    endtask
`endif

    initial begin
        do_fill = 1'b0;
`ifdef VRAM_ARB_CLEAR_EN
        clear_req = 1'b0;
`endif
        test_reset();
        test_fetch_sweep();
        test_line_end();
        test_writer_stall();
        test_blanking_throughput();
`ifdef VRAM_ARB_CLEAR_EN
        test_clear();
        test_clear_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
